// File: rtl/vec_loader.sv
// vec_loader: producer-side front end for the max_comp datapath.
// Pops a length header and then that many tokens from an upstream FIFO,
// writes the first min(L, size) tokens to the vector RAM at addresses
// 0..N-1, pulses comp_start, waits for comp_done and reports done_out.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_in          begin loading one vector (honoured in IDLE only)
//   fifo_empty        upstream FIFO empty flag
//   fifo_rd_en        FIFO pop; fifo_data valid one cycle later
//   fifo_data         FIFO read data
//   wr_en/wr_addr/wr_data  vector RAM write port
//   length_out        tokens stored for the current vector
//   comp_start        one-cycle start pulse to max_comp
//   comp_done         done pulse from max_comp
//   done_out          one-cycle pulse when the vector has been processed
//   busy              high in every state except IDLE
//   err_out           (VEC_LOADER_ERR_EN only) sticky oversize-vector flag
//
// Build option: define VEC_LOADER_ERR_EN to add err_out.

module vec_loader #(
    parameter int size  = 3,
    parameter int width = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [width-1:0] fifo_data,
    output logic             wr_en,
    output logic [width-1:0] wr_addr,
    output logic [width-1:0] wr_data,
    output logic [width-1:0] length_out,
    output logic             comp_start,
    input  logic             comp_done,
    output logic             done_out,
`ifdef VEC_LOADER_ERR_EN
    output logic             err_out,
`endif
    output logic             busy
);

    localparam logic [width-1:0] SIZE_W = width'(size);

    typedef enum logic [2:0] {
        IDLE,
        GET_LEN,
        LEN_WAIT,
        LOAD,
        START,
        WAIT_DONE,
        DONE
    } state_t;

    state_t           state;
    logic [width-1:0] len_q;
    logic [width-1:0] issued;
    logic             data_pop;

    // The first token is popped already in LEN_WAIT (the header is visible
    // on fifo_data there), overlapping header decode with the token stream.
    // This gives comp_start exactly L+3 cycles after start_in.
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            GET_LEN:  fifo_rd_en = !fifo_empty;
            LEN_WAIT: fifo_rd_en = !fifo_empty && (fifo_data != '0);
            LOAD:     fifo_rd_en = !fifo_empty && (issued < len_q);
            default:  fifo_rd_en = 1'b0;
        endcase
    end

    assign data_pop   = fifo_rd_en && ((state == LEN_WAIT) || (state == LOAD));

    // RAM data comes straight from the FIFO in the cycle after the pop.
    assign wr_data    = wr_en ? fifo_data : '0;
    assign comp_start = (state == START);
    assign done_out   = (state == DONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            issued     <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            length_out <= '0;
`ifdef VEC_LOADER_ERR_EN
            err_out    <= 1'b0;
`endif
        end else begin
            // Tokens at index >= size are popped but never written.
            wr_en <= data_pop && (issued < SIZE_W);
            if (data_pop) begin
                wr_addr <= issued;
                issued  <= issued + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_in) begin
                        state  <= GET_LEN;
                        issued <= '0;
`ifdef VEC_LOADER_ERR_EN
                        err_out <= 1'b0;
`endif
                    end
                end
                GET_LEN: begin
                    if (fifo_rd_en) state <= LEN_WAIT;
                end
                LEN_WAIT: begin
                    len_q      <= fifo_data;
                    length_out <= (fifo_data > SIZE_W) ? SIZE_W : fifo_data;
`ifdef VEC_LOADER_ERR_EN
                    if (fifo_data > SIZE_W) err_out <= 1'b1;
`endif
                    state      <= (fifo_data == '0) ? DONE : LOAD;
                end
                LOAD: begin
                    // All L pops issued; the final write/discard happens in
                    // this cycle, so START never overlaps wr_en.
                    if (issued == len_q) state <= START;
                end
                START:     state <= WAIT_DONE;
                WAIT_DONE: if (comp_done) state <= DONE;
                DONE:      state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_loader.sv
// tb_vec_loader: self-checking bench for vec_loader (size=3, width=10).
// A FIFO model feeds the DUT; expected RAM writes are queued when the
// stimulus is loaded and compared as the DUT writes them.

module tb_vec_loader;

    localparam int SIZE  = 3;
    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_in;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data = '0;
    logic             wr_en;
    logic [WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] length_out;
    logic             comp_start;
    logic             comp_done;
    logic             done_out;
    logic             busy;
`ifdef VEC_LOADER_ERR_EN
    logic             err_out;
`endif

    vec_loader #(.size(SIZE), .width(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_in   (start_in),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .length_out (length_out),
        .comp_start (comp_start),
        .comp_done  (comp_done),
        .done_out   (done_out),
`ifdef VEC_LOADER_ERR_EN
        .err_out    (err_out),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO model: data appears one cycle after a pop.
    logic [WIDTH-1:0] mem [64];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_rd_en && (wp != rp)) begin
            fifo_data <= mem[rp % 64];
            rp        <= rp + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  wr_cnt = 0;
    int  cs_cnt = 0;

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", exp_q.size(), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr_addr, e.a);
                check("wr_data", wr_data, e.d);
            end
        end
        if (comp_start) begin
            cs_cnt++;
            check("wr_with_cs", wr_en, 0);
        end
    end

    task automatic push(input int v);
        mem[wp % 64] = v[WIDTH-1:0];
        wp++;
    endtask

    task automatic expw(input int a, input int d);
        wr_t e;
        e.a = a[WIDTH-1:0];
        e.d = d[WIDTH-1:0];
        exp_q.push_back(e);
    endtask

    task automatic do_start(output int s);
        @(negedge clk);
        start_in = 1'b1;
        s = cyc;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // sel 0: comp_start, sel 1: done_out. Returns -1 on timeout.
    task automatic wait_sig(input int sel, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((sel == 0) ? comp_start : done_out) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic finish_vec(input string tag);
        @(negedge clk);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        check({tag, "_done_pulse"}, done_out, 1);
        @(negedge clk);
        check({tag, "_done_clear"}, done_out, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    int s, at, w0, c0;

    initial begin
        rst       = 1'b1;
        start_in  = 1'b0;
        comp_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_cs", comp_start, 0);
        check("rst_done", done_out, 0);
        check("rst_len", length_out, 0);
        check("rst_rd_en", fifo_rd_en, 0);
`ifdef VEC_LOADER_ERR_EN
        check("rst_err", err_out, 0);
`endif
        rst = 1'b0;

        // 1: basic three-token vector
        push(3); push(5); push(9); push(2);
        expw(0, 5); expw(1, 9); expw(2, 2);
        do_start(s);
        wait_sig(0, at);
        check("t1_cs_lat", at - s, 6);
        check("t1_len", length_out, 3);
        check("t1_sb_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("t1_busy_wait", busy, 1);
        check("t1_no_done", done_out, 0);
        finish_vec("t1");

        // 2: zero-length vector
        push(0);
        c0 = cs_cnt;
        w0 = wr_cnt;
        do_start(s);
        wait_sig(1, at);
        check("t2_done_lat", at - s, 3);
        check("t2_no_cs", cs_cnt, c0);
        check("t2_no_wr", wr_cnt, w0);
        check("t2_len", length_out, 0);
        @(negedge clk);
        check("t2_done_clear", done_out, 0);
        check("t2_idle", busy, 0);

        // 3: oversize vector, excess popped and dropped
        push(5); push(1); push(2); push(3); push(4); push(6); push(7);
        expw(0, 1); expw(1, 2); expw(2, 3);
        do_start(s);
        wait_sig(0, at);
        check("t3_cs_lat", at - s, 8);
        check("t3_len", length_out, 3);
        check("t3_fifo_left", wp - rp, 1);
`ifdef VEC_LOADER_ERR_EN
        check("t3_err", err_out, 1);
`endif
        finish_vec("t3");
`ifdef VEC_LOADER_ERR_EN
        check("t3_err_sticky", err_out, 1);
`endif
        // leftover 7 becomes the next header
        for (int i = 0; i < 7; i++) push(11 + i);
        expw(0, 11); expw(1, 12); expw(2, 13);
        do_start(s);
`ifdef VEC_LOADER_ERR_EN
        check("t3b_err_clr", err_out, 0);
`endif
        wait_sig(0, at);
        check("t3b_cs_lat", at - s, 10);
        check("t3b_len", length_out, 3);
        check("t3b_fifo_left", wp - rp, 0);
        finish_vec("t3b");

        // 4: FIFO runs dry mid-vector
        push(3); push(8);
        expw(0, 8); expw(1, 1); expw(2, 4);
        w0 = wr_cnt;
        c0 = cs_cnt;
        do_start(s);
        repeat (6) @(negedge clk);
        check("t4_stall_wr", wr_cnt - w0, 1);
        check("t4_stall_busy", busy, 1);
        check("t4_stall_cs", cs_cnt, c0);
        push(1); push(4);
        wait_sig(0, at);
        check("t4_cs_seen", at > 0, 1);
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_len", length_out, 3);
        finish_vec("t4");

        // 5: reset during LOAD
        push(3); push(1); push(2); push(3);
        expw(0, 1);
        do_start(s);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en) break;
        end
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_wr_data", wr_data, 0);
        check("t5_wr_addr", wr_addr, 0);
        check("t5_len", length_out, 0);
        check("t5_cs", comp_start, 0);
        check("t5_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        wp = rp;
        exp_q.delete();
        push(2); push(7); push(6);
        expw(0, 7); expw(1, 6);
        do_start(s);
        wait_sig(0, at);
        check("t5_cs_lat", at - s, 5);
        check("t5_len2", length_out, 2);
        check("t5_sb_empty", exp_q.size(), 0);
        finish_vec("t5");

        // 6: start_in in WAIT_DONE and comp_done in IDLE are ignored
        push(1); push(9);
        expw(0, 9);
        do_start(s);
        wait_sig(0, at);
        check("t6_cs_lat", at - s, 4);
        @(negedge clk);
        start_in = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_busy", busy, 1);
        check("t6_no_done", done_out, 0);
        start_in  = 1'b0;
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        check("t6_done", done_out, 1);
        @(negedge clk);
        check("t6_idle", busy, 0);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_idle_busy", busy, 0);
            check("t6_idle_done", done_out, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
